// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory word sequencer.
// State encoding, byte-lane map of the two beats, default widths.
package dmem_pkg;

    localparam int MEM_AW_DEF  = 10;
    localparam int BANK_DW_DEF = 8;
    localparam int CPU_AW      = MEM_AW_DEF + 2;
    localparam int LATENCY     = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT0,
        S_BEAT1,
        S_FIN
    } state_e;

    // Byte lanes of the CPU word carried on each bank per beat.
    localparam int B0_LO_LANE = 0;
    localparam int B0_HI_LANE = 1;
    localparam int B1_LO_LANE = 2;
    localparam int B1_HI_LANE = 3;

endpackage

// File: rtl/dmem_word_sequencer.sv
// Splits one 32-bit CPU data request into two 16-bit beats on a pair
// of 8-bit single-port BRAM banks (mem_lo / mem_hi).
//
// Ports:
//   clk_i, rst_n_i       clock, async active-low reset
//   req_i / ready_o      request handshake (accepted when both high)
//   we_i, addr_i, be_i   write flag, byte address, byte enables
//   wdata_i              write data
//   ack_o, err_o         completion pulse, misaligned flag (with ack)
//   rdata_o              read data, valid with ack
//   mem_addr_o, mem_ce_o shared bank address and clock enable
//   mem_we_lo/hi_o       per-bank write enables
//   mem_di_lo/hi_o       per-bank write data
//   mem_do_lo/hi_i       per-bank read data (1-cycle latency)
module dmem_word_sequencer
    import dmem_pkg::*;
#(
    parameter int MEM_AW  = MEM_AW_DEF,
    parameter int BANK_DW = BANK_DW_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 req_i,
    output logic                 ready_o,
    input  logic                 we_i,
    input  logic [MEM_AW+1:0]    addr_i,
    input  logic [3:0]           be_i,
    input  logic [4*BANK_DW-1:0] wdata_i,
    output logic                 ack_o,
    output logic                 err_o,
    output logic [4*BANK_DW-1:0] rdata_o,
    output logic [MEM_AW-1:0]    mem_addr_o,
    output logic                 mem_ce_o,
    output logic                 mem_we_lo_o,
    output logic                 mem_we_hi_o,
    output logic [BANK_DW-1:0]   mem_di_lo_o,
    output logic [BANK_DW-1:0]   mem_di_hi_o,
    input  logic [BANK_DW-1:0]   mem_do_lo_i,
    input  logic [BANK_DW-1:0]   mem_do_hi_i
);

    localparam int HW = 2 * BANK_DW;
    localparam int WW = 4 * BANK_DW;

    state_e state_q, state_d;

    // Request latched at accept (beat-1 fields only; beat 0 is
    // issued straight from the request inputs).
    logic [MEM_AW-2:0] w_q;
    logic              we_q;
    logic [1:0]        be_hi_q;
    logic [HW-1:0]     wd_hi_q;
    logic              err_q, err_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              ld;

    logic [WW-1:0]     rdata_q, rdata_d;
    logic              ack_d, erro_d;
    logic [MEM_AW-1:0] addr_d;
    logic              ce_d, we_lo_d, we_hi_d;
    logic [BANK_DW-1:0] di_lo_d, di_hi_d;

    // Two banks of 2^MEM_AW bytes hold 2^(MEM_AW+1) bytes, so the top
    // CPU address bit aliases onto the lower half.
    logic unused_addr_msb;
    assign unused_addr_msb = addr_i[MEM_AW+1];

    assign ready_o = (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ld      = 1'b0;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        erro_d  = 1'b0;
        addr_d  = '0;
        ce_d    = 1'b0;
        we_lo_d = 1'b0;
        we_hi_d = 1'b0;
        di_lo_d = '0;
        di_hi_d = '0;
        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    ld = 1'b1;
                    if (addr_i[1:0] != 2'b00) begin
                        // Wait out the remaining cycles in FIN so the
                        // error ack keeps the fixed latency.
                        state_d = S_FIN;
                        err_d   = 1'b1;
                        cnt_d   = 2'(LATENCY - 1);
                    end else begin
                        state_d = S_BEAT0;
                        err_d   = 1'b0;
                        cnt_d   = 2'd0;
                        ce_d    = 1'b1;
                        addr_d  = {addr_i[MEM_AW:2], 1'b0};
                        we_lo_d = we_i & be_i[B0_LO_LANE];
                        we_hi_d = we_i & be_i[B0_HI_LANE];
                        di_lo_d = wdata_i[B0_LO_LANE*BANK_DW +: BANK_DW];
                        di_hi_d = wdata_i[B0_HI_LANE*BANK_DW +: BANK_DW];
                    end
                end
            end
            S_BEAT0: begin
                state_d = S_BEAT1;
                ce_d    = 1'b1;
                addr_d  = {w_q, 1'b1};
                we_lo_d = we_q & be_hi_q[0];
                we_hi_d = we_q & be_hi_q[1];
                di_lo_d = wd_hi_q[0 +: BANK_DW];
                di_hi_d = wd_hi_q[BANK_DW +: BANK_DW];
            end
            S_BEAT1: begin
                state_d = S_FIN;
                if (!we_q) begin
                    rdata_d[HW-1:0] = {mem_do_hi_i, mem_do_lo_i};
                end
            end
            S_FIN: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    state_d = S_IDLE;
                    ack_d   = 1'b1;
                    erro_d  = err_q;
                    if (!we_q && !err_q) begin
                        rdata_d[WW-1:HW] = {mem_do_hi_i, mem_do_lo_i};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            w_q         <= '0;
            we_q        <= 1'b0;
            be_hi_q     <= '0;
            wd_hi_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            ack_o       <= 1'b0;
            err_o       <= 1'b0;
            mem_addr_o  <= '0;
            mem_ce_o    <= 1'b0;
            mem_we_lo_o <= 1'b0;
            mem_we_hi_o <= 1'b0;
            mem_di_lo_o <= '0;
            mem_di_hi_o <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            ack_o       <= ack_d;
            err_o       <= erro_d;
            mem_addr_o  <= addr_d;
            mem_ce_o    <= ce_d;
            mem_we_lo_o <= we_lo_d;
            mem_we_hi_o <= we_hi_d;
            mem_di_lo_o <= di_lo_d;
            mem_di_hi_o <= di_hi_d;
            if (ld) begin
                w_q     <= addr_i[MEM_AW:2];
                we_q    <= we_i;
                be_hi_q <= {be_i[B1_HI_LANE], be_i[B1_LO_LANE]};
                wd_hi_q <= wdata_i[WW-1:HW];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule
